// File: rtl/bus_responder.sv
// Single-outstanding bus target: 8-beat line writes into a line store and
// fixed-latency 8-beat line reads with per-beat response backpressure.
module bus_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_LINES      = 64,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int WR_BIT = 12;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] LAT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                    state_r, state_s;
  logic [BUS_DATA_WIDTH-1:0] store_r [MEM_LINES][8];
  logic [BUS_DATA_WIDTH-1:0] wbuf_r [8];
  logic [BUS_DATA_WIDTH-1:0] rbuf_r [8];
  logic [IDX_W-1:0]          idx_r;
  logic [IDX_W-1:0]          addr_idx_s;
  logic [2:0]                beat_r;
  logic [CNT_W-1:0]          lat_r;
  logic [BUS_TAG_WIDTH-1:0]  tag_r;
  logic                      resp_cyc_r;
  logic [BUS_DATA_WIDTH-1:0] resp_data_r;
  logic [BUS_TAG_WIDTH-1:0]  resp_tag_r;
  logic                      req_xfer_s;
  logic                      resp_xfer_s;
  logic                      last_beat_s;
  logic                      wr_commit_s;
  logic                      rd_accept_s;

  // 64-byte lines: bits 5:0 select a byte within the line, upper bits alias.
  assign addr_idx_s  = bus_req[6 +: IDX_W];
  assign bus_reqack  = bus_reqcyc && ((state_r == IDLE) || (state_r == WDATA));
  assign req_xfer_s  = bus_reqack;
  assign resp_xfer_s = resp_cyc_r && bus_respack;
  assign last_beat_s = (beat_r == 3'd7);
  assign wr_commit_s = (state_r == WDATA) && req_xfer_s && last_beat_s;
  assign rd_accept_s = (state_r == IDLE) && req_xfer_s && !bus_reqtag[WR_BIT];

  assign bus_respcyc = resp_cyc_r;
  assign bus_resp    = resp_data_r;
  assign bus_resptag = resp_tag_r;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_xfer_s) state_s = bus_reqtag[WR_BIT] ? WDATA : WAIT;
        else            state_s = IDLE;
      end
      WDATA: begin
        if (wr_commit_s) state_s = IDLE;
        else             state_s = WDATA;
      end
      WAIT: begin
        if (lat_r == LAT_ONE) state_s = RESP;
        else                  state_s = WAIT;
      end
      RESP: begin
        if (resp_xfer_s && last_beat_s) state_s = IDLE;
        else                            state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Line store and beat buffers; deliberately not reset so contents survive reset.
  always_ff @(posedge clk) begin
    if ((state_r == WDATA) && req_xfer_s) wbuf_r[beat_r] <= bus_req;
    if (wr_commit_s) begin
      for (int w = 0; w < 7; w++) store_r[idx_r][w] <= wbuf_r[w];
      store_r[idx_r][7] <= bus_req;
    end
    // Snapshot at accept so the response never sees a later store update.
    if (rd_accept_s) begin
      for (int w = 0; w < 8; w++) rbuf_r[w] <= store_r[addr_idx_s][w];
    end
  end

  // Control state, counters and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      beat_r      <= 3'd0;
      lat_r       <= {CNT_W{1'b0}};
      tag_r       <= {BUS_TAG_WIDTH{1'b0}};
      resp_cyc_r  <= 1'b0;
      resp_data_r <= {BUS_DATA_WIDTH{1'b0}};
      resp_tag_r  <= {BUS_TAG_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (req_xfer_s) begin
            idx_r  <= addr_idx_s;
            tag_r  <= bus_reqtag;
            beat_r <= 3'd0;
            lat_r  <= LAT_LOAD;
          end
        end
        WDATA: begin
          if (req_xfer_s) beat_r <= beat_r + 3'd1;
        end
        WAIT: begin
          lat_r <= lat_r - LAT_ONE;
          if (lat_r == LAT_ONE) begin
            resp_cyc_r  <= 1'b1;
            resp_data_r <= rbuf_r[0];
            resp_tag_r  <= tag_r;
          end
        end
        RESP: begin
          if (resp_xfer_s) begin
            beat_r <= beat_r + 3'd1;
            if (last_beat_s) begin
              resp_cyc_r  <= 1'b0;
              resp_data_r <= {BUS_DATA_WIDTH{1'b0}};
              resp_tag_r  <= {BUS_TAG_WIDTH{1'b0}};
            end else begin
              resp_data_r <= rbuf_r[beat_r + 3'd1];
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: directed vector table, hand-built reset/backpressure
// sequences, then random traffic checked against a line-array model.
module tb_bus_responder;

  localparam int LINES = 64;
  localparam int LAT   = 4;
  localparam int NONE  = 8;

  typedef logic [7:0][63:0] line_t;
  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [12:0] tag;
    logic [63:0] base;
    logic [63:0] step;
    int          gap_at;
    int          stall_beat;
    int          stall_len;
    bit          noise;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_reqcyc = 1'b0;
  logic [63:0] bus_req = 64'd0;
  logic [12:0] bus_reqtag = 13'd0;
  logic        bus_respack = 1'b0;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  int    checks = 0;
  int    errors = 0;
  line_t model_mem [LINES];
  bit    model_valid [LINES];

  bus_responder #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .MEM_LINES(LINES), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int line_idx(input logic [63:0] addr);
    return int'((addr / 64'd64) % 64'(LINES));
  endfunction

  function automatic line_t make_line(input logic [63:0] base, input logic [63:0] step);
    line_t l;
    for (int k = 0; k < 8; k++) l[k] = base + 64'(k) * step;
    return l;
  endfunction

  task automatic drive_noise(input bit noise);
    if (noise) begin
      bus_reqcyc = 1'($urandom_range(0, 1));
      bus_req    = {$urandom, $urandom};
      bus_reqtag = 13'($urandom);
    end else begin
      bus_reqcyc = 1'b0;
    end
  endtask

  // Every transaction starts 1 time unit after a rising edge with the DUT idle.
  task automatic chk_idle_outputs();
    chk("idle_respcyc", 64'(bus_respcyc), 64'd0);
    chk("idle_resp", bus_resp, 64'd0);
    chk("idle_resptag", 64'(bus_resptag), 64'd0);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input line_t d, input int gap_at);
    int acks = 0;
    int resp_seen = 0;
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
    @(negedge clk);
    chk_idle_outputs();
    if (bus_reqack) acks++;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) begin
        bus_reqcyc = 1'b0; bus_req = 64'hDEAD_DEAD_DEAD_DEAD;
        repeat (2) begin
          @(negedge clk);
          if (bus_reqack) acks++;
          if (bus_respcyc) resp_seen++;
          @(posedge clk); #1;
        end
      end
      bus_reqcyc = 1'b1; bus_req = d[k];
      @(negedge clk);
      if (bus_reqack) acks++;
      if (bus_respcyc) resp_seen++;
      @(posedge clk); #1;
    end
    bus_reqcyc = 1'b0;
    chk("wr_reqack_cycles", 64'(acks), 64'd9);
    chk("wr_no_resp", 64'(resp_seen), 64'd0);
    model_mem[line_idx(addr)]   = d;
    model_valid[line_idx(addr)] = 1'b1;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input line_t exp,
                         input int stall_beat, input int stall_len, input bit noise);
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b0;
    @(negedge clk);
    chk_idle_outputs();
    chk("rd_addr_ack", 64'(bus_reqack), 64'd1);
    @(posedge clk); #1;
    for (int c = 1; c <= LAT; c++) begin
      drive_noise(noise);
      bus_respack = noise;
      @(negedge clk);
      chk("rd_latency_respcyc", 64'(bus_respcyc), 64'd0);
      chk("wait_reqack", 64'(bus_reqack), 64'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++) begin
      if (k == stall_beat) begin
        bus_respack = 1'b0;
        repeat (stall_len) begin
          drive_noise(noise);
          @(negedge clk);
          chk("stall_respcyc", 64'(bus_respcyc), 64'd1);
          chk("stall_resp", bus_resp, exp[k]);
          chk("stall_resptag", 64'(bus_resptag), 64'(tag));
          @(posedge clk); #1;
        end
      end
      bus_respack = 1'b1;
      drive_noise(noise);
      @(negedge clk);
      chk("beat_respcyc", 64'(bus_respcyc), 64'd1);
      chk("beat_resp", bus_resp, exp[k]);
      chk("beat_resptag", 64'(bus_resptag), 64'(tag));
      chk("resp_reqack", 64'(bus_reqack), 64'd0);
      @(posedge clk); #1;
    end
    bus_respack = 1'b0; bus_reqcyc = 1'b0;
  endtask

  initial begin
    vec_t        vecs [9];
    line_t       l;
    logic [63:0] a;
    int          idx;
    int          seen;

    vecs[0] = '{1'b1, 64'h1040,                13'h1005, 64'h11,                  64'h11,    NONE, NONE, 0, 1'b0};
    vecs[1] = '{1'b0, 64'h1040,                13'h0007, 64'h11,                  64'h11,    NONE, NONE, 0, 1'b0};
    vecs[2] = '{1'b0, 64'h2040,                13'h0123, 64'h11,                  64'h11,    NONE, 2,    3, 1'b1};
    vecs[3] = '{1'b1, 64'h2040,                13'h1ABC, 64'hA000,                64'h101,   3,    NONE, 0, 1'b0};
    vecs[4] = '{1'b0, 64'h1040,                13'h0FFF, 64'hA000,                64'h101,   NONE, 0,    1, 1'b0};
    vecs[5] = '{1'b1, 64'h0080,                13'h1001, 64'hDEADBEEF_00000000,   64'h1,     NONE, NONE, 0, 1'b0};
    vecs[6] = '{1'b0, 64'hFFFF0000_00000080,   13'h0002, 64'hDEADBEEF_00000000,   64'h1,     NONE, NONE, 0, 1'b1};
    vecs[7] = '{1'b1, 64'h0FFF,                13'h1FFF, 64'h5555,                64'h1111_0000_0000_0000, 0, NONE, 0, 1'b0};
    vecs[8] = '{1'b0, 64'h0FC0,                13'h0AAA, 64'h5555,                64'h1111_0000_0000_0000, NONE, 7, 2, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_respcyc", 64'(bus_respcyc), 64'd0);
    chk("reset_resp", bus_resp, 64'd0);
    chk("reset_resptag", 64'(bus_resptag), 64'd0);
    chk("reset_reqack_no_cyc", 64'(bus_reqack), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      l = make_line(vecs[i].base, vecs[i].step);
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].tag, l, vecs[i].gap_at);
      else do_read(vecs[i].addr, vecs[i].tag, l, vecs[i].stall_beat, vecs[i].stall_len, vecs[i].noise);
    end

    // Reset after 5 of 8 write beats: line 1 must keep its earlier contents.
    bus_reqcyc = 1'b1; bus_req = 64'h1040; bus_reqtag = 13'h1777;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      bus_req = 64'hBAD0_0000 + 64'(k);
      @(posedge clk); #1;
    end
    reset = 1'b1; bus_reqcyc = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    do_read(64'h1040, 13'h0011, make_line(64'hA000, 64'h101), NONE, 0, 1'b0);

    // Reset while beat 3 of a read is on the bus.
    bus_reqcyc = 1'b1; bus_req = 64'h0080; bus_reqtag = 13'h0055; bus_respack = 1'b0;
    @(posedge clk); #1;
    bus_reqcyc = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    bus_respack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_respack = 1'b0;
    @(negedge clk);
    l = make_line(64'hDEADBEEF_00000000, 64'h1);
    chk("pre_reset_respcyc", 64'(bus_respcyc), 64'd1);
    chk("pre_reset_resp", bus_resp, l[3]);
    reset = 1'b1;
    #1;
    chk("rst_respcyc_now", 64'(bus_respcyc), 64'd0);
    chk("rst_resp_now", bus_resp, 64'd0);
    chk("rst_resptag_now", 64'(bus_resptag), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus_respack = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_respcyc) seen++;
      @(posedge clk); #1;
    end
    bus_respack = 1'b0;
    chk("post_reset_silent", 64'(seen), 64'd0);

    // Random traffic over a handful of lines so reads hit earlier writes.
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      a[11:6] = 6'($urandom_range(0, 7));
      idx = line_idx(a);
      if (model_valid[idx] && ($urandom_range(0, 2) != 0)) begin
        do_read(a, {1'b0, 12'($urandom)}, model_mem[idx], int'($urandom_range(0, 8)),
                int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      end else begin
        for (int k = 0; k < 8; k++) l[k] = {$urandom, $urandom};
        do_write(a, {1'b1, 12'($urandom)}, l, int'($urandom_range(0, 8)));
      end
    end

    @(negedge clk);
    chk_idle_outputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
